// File: rtl/dot_seq.sv
// Dot-product job sequencer: feeds operand beats to an external array and sums its two partial outputs.
// Optional build macro DOT_SEQ_OPGATE_EN zeroes the array operands on cycles without an operand handshake.
module dot_seq #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int ARRAY_SIZE = 8,
    parameter int OUT_SIZE   = 16,
    parameter int PIPE_LAT   = 3,
    parameter int LEN_W      = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [LEN_W-1:0]                 cmd_len_i,
    input  logic                             op_valid_i,
    output logic                             op_ready_o,
    input  logic [ARRAY_SIZE*IN_SIZE_0-1:0]  op_in_0_i,
    input  logic [ARRAY_SIZE*IN_SIZE_1-1:0]  op_in_1_i,
    output logic [ARRAY_SIZE*IN_SIZE_0-1:0]  arr_in_0_o,
    output logic [ARRAY_SIZE*IN_SIZE_1-1:0]  arr_in_1_o,
    input  logic [OUT_SIZE-1:0]              arr_out_0_i,
    input  logic [OUT_SIZE-1:0]              arr_out_1_i,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic [OUT_SIZE+LEN_W:0]          res_o,
    output logic                             busy_o
);
    // state | meaning
    // IDLE  | waiting for a command
    // FEED  | accepting operand beats until remaining reaches zero
    // DRAIN | waiting for in-flight beats to leave the array
    // DONE  | presenting the result until accepted
    localparam int ACC_SIZE = OUT_SIZE + LEN_W + 1;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                            state_q, state_d;
    logic [LEN_W-1:0]                  rem_q, rem_d;
    logic [PIPE_LAT:0]                 tag_q, tag_d;
    logic [ACC_SIZE-1:0]               acc_q, acc_d;
    logic [ARRAY_SIZE*IN_SIZE_0-1:0]   arr0_q, arr0_d;
    logic [ARRAY_SIZE*IN_SIZE_1-1:0]   arr1_q, arr1_d;
    logic                              op_hs;
    logic [ACC_SIZE-1:0]               ext0, ext1;

    assign cmd_ready_o = (state_q == IDLE);
    assign op_ready_o  = (state_q == FEED) && (rem_q != '0);
    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign res_o       = (state_q == DONE) ? acc_q : '0;
    assign arr_in_0_o  = arr0_q;
    assign arr_in_1_o  = arr1_q;
    assign op_hs       = op_valid_i && op_ready_o;
    assign ext0        = {{(ACC_SIZE-OUT_SIZE){arr_out_0_i[OUT_SIZE-1]}}, arr_out_0_i};
    assign ext1        = {{(ACC_SIZE-OUT_SIZE){arr_out_1_i[OUT_SIZE-1]}}, arr_out_1_i};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        tag_d   = {tag_q[PIPE_LAT-1:0], op_hs};
`ifdef DOT_SEQ_OPGATE_EN
        arr0_d  = op_hs ? op_in_0_i : '0;
        arr1_d  = op_hs ? op_in_1_i : '0;
`else
        arr0_d  = op_hs ? op_in_0_i : arr0_q;
        arr1_d  = op_hs ? op_in_1_i : arr1_q;
`endif
        // the tag leaving the delay line marks the cycle its array output is valid
        if (tag_q[PIPE_LAT]) begin
            acc_d = acc_q + ext0 + ext1;
        end
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    rem_d   = cmd_len_i;
                    acc_d   = '0;
                    state_d = (cmd_len_i != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (op_hs) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tag_q[PIPE_LAT] && (tag_q[PIPE_LAT-1:0] == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
            arr0_q  <= '0;
            arr1_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
            arr0_q  <= arr0_d;
            arr1_q  <= arr1_d;
        end
    end
endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq with a behavioural array model and a plain-arithmetic dot-product reference.
module tb_dot_seq;
    localparam int IN0 = 4, IN1 = 8, AS = 8, OS = 16, PL = 3, LW = 8;
    localparam int ACC = OS + LW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              cmd_valid, cmd_ready, op_valid, op_ready, res_valid, res_ready, busy;
    logic [LW-1:0]     cmd_len;
    logic [AS*IN0-1:0] op_in0, arr_in0;
    logic [AS*IN1-1:0] op_in1, arr_in1;
    logic [OS-1:0]     arr_out0, arr_out1;
    logic [ACC-1:0]    res;

    int checks = 0;
    int errors = 0;

    logic [AS*IN0-1:0] b0 [16];
    logic [AS*IN1-1:0] b1 [16];

    dot_seq #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS), .OUT_SIZE(OS),
              .PIPE_LAT(PL), .LEN_W(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
        .op_valid_i(op_valid), .op_ready_o(op_ready),
        .op_in_0_i(op_in0), .op_in_1_i(op_in1),
        .arr_in_0_o(arr_in0), .arr_in_1_o(arr_in1),
        .arr_out_0_i(arr_out0), .arr_out_1_i(arr_out1),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res), .busy_o(busy)
    );

    // external array: two half-array partial sums, PL cycles after arr_in changes
    function automatic logic [OS-1:0] half_sum(input logic [AS*IN0-1:0] a, input logic [AS*IN1-1:0] b, input int h);
        longint s = 0;
        for (int i = h * AS / 2; i < (h + 1) * AS / 2; i++)
            s += longint'($signed(a[i*IN0 +: IN0])) * longint'($signed(b[i*IN1 +: IN1]));
        return OS'(s);
    endfunction

    logic [OS-1:0] p0 [PL];
    logic [OS-1:0] p1 [PL];
    always @(posedge clk) begin
        p0[0] <= half_sum(arr_in0, arr_in1, 0);
        p1[0] <= half_sum(arr_in0, arr_in1, 1);
        for (int k = 1; k < PL; k++) begin
            p0[k] <= p0[k-1];
            p1[k] <= p1[k-1];
        end
    end
    assign arr_out0 = p0[PL-1];
    assign arr_out1 = p1[PL-1];

    function automatic longint dot(input logic [AS*IN0-1:0] a, input logic [AS*IN1-1:0] b);
        longint s = 0;
        for (int i = 0; i < AS; i++)
            s += longint'($signed(a[i*IN0 +: IN0])) * longint'($signed(b[i*IN1 +: IN1]));
        return s;
    endfunction

    function automatic longint job_ref(input int len);
        longint s = 0;
        for (int i = 0; i < len; i++) s += dot(b0[i], b1[i]);
        return s;
    endfunction

    task automatic fill_beat(input int idx, input int v0, input int v1);
        for (int i = 0; i < AS; i++) begin
            b0[idx][i*IN0 +: IN0] = IN0'(v0);
            b1[idx][i*IN1 +: IN1] = IN1'(v1);
        end
    endtask

    task automatic do_cmd(input int len, output bit ok);
        int g = 0;
        ok = 1'b1;
        cmd_valid = 1'b1;
        cmd_len = LW'(len);
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input int len, input int gmin, input int gmax, input int rdy_dly, input bit junk,
                           output longint r, output int lat, output bit stable, output bit ok);
        int cyc, idx, gap, first, g;
        logic [ACC-1:0] held;
        do_cmd(len, ok);
        cyc = 1; idx = 0; gap = 0; first = 0; stable = 1'b1;
        while (idx < len && cyc < 2000) begin
            if (gap > 0) begin
                op_valid = 1'b0;
                op_in0 = $urandom;
                op_in1 = {$urandom, $urandom};
                gap--;
            end else begin
                op_valid = 1'b1;
                op_in0 = b0[idx];
                op_in1 = b1[idx];
            end
            if (op_valid && op_ready) begin
                if (idx == 0) first = cyc;
                idx++;
                gap = $urandom_range(gmax, gmin);
            end
            @(negedge clk);
            cyc++;
        end
        op_valid = junk;
        op_in0 = $urandom;
        op_in1 = {$urandom, $urandom};
        g = 0;
        while (!res_valid && g < 200) begin
            @(negedge clk);
            cyc++;
            g++;
        end
        if (!res_valid) ok = 1'b0;
        lat = cyc - first;
        held = res;
        r = $signed(res);
        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge clk);
            if (res !== held || !res_valid || cmd_ready) stable = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rst_op_ready got %b exp 0", op_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        checks++; if (res !== '0) begin errors++; $display("FAIL rst_res got %0d exp 0", res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (arr_in0 !== '0 || arr_in1 !== '0) begin errors++; $display("FAIL rst_arr_in got %h/%h exp 0", arr_in0, arr_in1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_len1;
        longint r; int lat; bit st, ok;
        fill_beat(0, 7, 127);
        run_job(1, 0, 0, 0, 1'b0, r, lat, st, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len1_timeout got 0 exp 1"); end
        checks++; if (r !== 64'sd7112) begin errors++; $display("FAIL len1_res got %0d exp 7112", r); end
        checks++; if (lat !== PL + 2) begin errors++; $display("FAIL len1_latency got %0d exp %0d", lat, PL + 2); end
    endtask

    task automatic test_len4;
        longint r; int lat; bit st, ok;
        for (int i = 0; i < 4; i++) fill_beat(i, -8, -128);
        run_job(4, 0, 0, 0, 1'b0, r, lat, st, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len4_timeout got 0 exp 1"); end
        checks++; if (r !== 64'sd32768) begin errors++; $display("FAIL len4_res got %0d exp 32768", r); end
        checks++; if (lat !== 4 + PL + 1) begin errors++; $display("FAIL len4_latency got %0d exp %0d", lat, 4 + PL + 1); end
    endtask

    task automatic test_len0;
        bit ok;
        do_cmd(0, ok);
        checks++; if (!ok || res_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %b exp 1", res_valid); end
        checks++; if (res !== '0) begin errors++; $display("FAIL len0_res got %0d exp 0", res); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL len0_op_ready got %b exp 0", op_ready); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_gaps;
        longint r; int lat; bit st, ok;
        for (int i = 0; i < 3; i++) fill_beat(i, 1, 1);
        run_job(3, 2, 2, 5, 1'b1, r, lat, st, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gaps_timeout got 0 exp 1"); end
        checks++; if (r !== 64'sd24) begin errors++; $display("FAIL gaps_res got %0d exp 24", r); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL gaps_hold_stable got %b exp 1", st); end
    endtask

    task automatic test_reset_mid;
        longint r; int lat; bit st, ok;
        int n = 0;
        for (int i = 0; i < 4; i++) fill_beat(i, 3, 5);
        do_cmd(4, ok);
        for (int g = 0; g < 20 && n < 2; g++) begin
            op_valid = 1'b1;
            op_in0 = b0[n];
            op_in1 = b1[n];
            if (op_ready) n++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_op_ready got %b exp 0", op_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_res_valid got %b exp 0", res_valid); end
        checks++; if (res !== '0) begin errors++; $display("FAIL mid_rst_res got %0d exp 0", res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        checks++; if (arr_in0 !== '0 || arr_in1 !== '0) begin errors++; $display("FAIL mid_rst_arr_in got %h/%h exp 0", arr_in0, arr_in1); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_beat(0, 7, -128);
        run_job(1, 0, 0, 0, 1'b0, r, lat, st, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_rst_timeout got 0 exp 1"); end
        checks++; if (r !== -64'sd7168) begin errors++; $display("FAIL mid_rst_res got %0d exp -7168", r); end
    endtask

    task automatic test_opgate;
        bit ok;
        int g = 0;
        longint exp_r;
        logic [AS*IN0-1:0] a0, e0;
        logic [AS*IN1-1:0] a1, e1;
        a0 = $urandom | 32'h1;
        a1 = {$urandom, $urandom} | 64'h1;
        b0[1] = $urandom;
        b1[1] = {$urandom, $urandom};
        exp_r = dot(a0, a1) + dot(b0[1], b1[1]);
        do_cmd(2, ok);
        op_valid = 1'b1; op_in0 = a0; op_in1 = a1;
        @(negedge clk);
        checks++; if (arr_in0 !== a0 || arr_in1 !== a1) begin errors++; $display("FAIL opgate_load got %h/%h exp %h/%h", arr_in0, arr_in1, a0, a1); end
        op_valid = 1'b0; op_in0 = ~a0; op_in1 = ~a1;
        @(negedge clk);
`ifdef DOT_SEQ_OPGATE_EN
        e0 = '0; e1 = '0;
`else
        e0 = a0; e1 = a1;
`endif
        checks++; if (arr_in0 !== e0 || arr_in1 !== e1) begin errors++; $display("FAIL opgate_idle got %h/%h exp %h/%h", arr_in0, arr_in1, e0, e1); end
        op_valid = 1'b1; op_in0 = b0[1]; op_in1 = b1[1];
        @(negedge clk);
        op_valid = 1'b0;
        while (!res_valid && g < 100) begin @(negedge clk); g++; end
        checks++; if (res_valid !== 1'b1 || $signed(res) !== ACC'(exp_r)) begin errors++; $display("FAIL opgate_res got %0d exp %0d", $signed(res), exp_r); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_random;
        longint r, e; int lat, len, gmax; bit st, ok;
        for (int j = 0; j < 20; j++) begin
            len = $urandom_range(8, 0);
            gmax = (j % 2 == 0) ? 0 : 3;
            for (int i = 0; i < len; i++) begin
                b0[i] = $urandom;
                b1[i] = {$urandom, $urandom};
            end
            e = job_ref(len);
            run_job(len, 0, gmax, $urandom_range(3, 0), 1'b1, r, lat, st, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_timeout job %0d got 0 exp 1", j); end
            checks++; if (r !== e) begin errors++; $display("FAIL rand_res job %0d got %0d exp %0d", j, r, e); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand_hold job %0d got %b exp 1", j, st); end
            if (gmax == 0) begin
                checks++;
                if (lat !== ((len == 0) ? 1 : len + PL + 1)) begin
                    errors++;
                    $display("FAIL rand_latency job %0d got %0d exp %0d", j, lat, (len == 0) ? 1 : len + PL + 1);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_len = '0;
        op_valid = 1'b0; op_in0 = '0; op_in1 = '0;
        res_ready = 1'b0;
        test_reset;
        test_len1;
        test_len4;
        test_len0;
        test_gaps;
        test_reset_mid;
        test_opgate;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
